// File: rtl/controle_jogo.sv
// Game-state controller: ship/enemy-ball hit detection, kill scoring, lives and the top-level game FSM.
// Optional invulnerability window after a hit when CONTROLE_INVULNERAVEL_EN is defined.
module controle_jogo #(
    parameter int LARGURA_NAVE = 45,
    parameter int ALTURA_NAVE  = 20,
    parameter int VIDAS_INI    = 3,
    parameter int PONTOS_KILL  = 10,
    parameter int PONTOS_MAX   = 999
`ifdef CONTROLE_INVULNERAVEL_EN
    , parameter int INV_CICLOS = 50000000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] keysout,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] x_bola_inimiga,
    input  logic [9:0] y_bola_inimiga,
    input  logic [9:0] raio_bola_inimiga,
    input  logic [0:4] inimigo_vivo_array,
    output logic       pausa,
    output logic       reiniciarJogo,
    output logic [1:0] estado,
    output logic [1:0] vidas,
    output logic [9:0] pontos,
    output logic       vitoria
);

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        JOGANDO = 2'd1,
        PAUSADO = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t     est, est_n;
    logic [1:0]  vidas_n;
    logic [9:0]  pontos_n, pontos_sat;
    logic        vitoria_n, reiniciar_n;

    logic [1:0]  key_q, key_prev;
    logic        ev_start, ev_pausa;
    logic        sobrepoe, sobre_q, sobre_prev, hit, hit_ok;
    logic [0:4]  prev_vivo, kill_mask;
    logic [2:0]  n_kills;
    logic [12:0] soma;
    logic [11:0] xb, yb, r, xn, yn;
    logic        unused_keys;

    assign unused_keys = ^keysout[3:2];

    assign ev_start = key_q[0] & ~key_prev[0];
    assign ev_pausa = key_q[1] & ~key_prev[1];

    // One extra bit beyond 11 so x+W+r at the top of the 10-bit range cannot wrap.
    assign xb = {2'b00, x_bola_inimiga};
    assign yb = {2'b00, y_bola_inimiga};
    assign r  = {2'b00, raio_bola_inimiga};
    assign xn = {2'b00, x_nave};
    assign yn = {2'b00, y_nave};

    assign sobrepoe = (xb + r >= xn) && (xb <= xn + 12'(LARGURA_NAVE) + r) &&
                      (yb + r >= yn) && (yb <= yn + 12'(ALTURA_NAVE) + r);
    assign hit = sobre_q & ~sobre_prev;

    assign kill_mask = prev_vivo & ~inimigo_vivo_array;

    always_comb begin
        n_kills = '0;
        for (int i = 0; i < 5; i++)
            n_kills = n_kills + {2'b00, kill_mask[i]};
    end

    assign soma       = 13'(pontos) + 13'(PONTOS_KILL) * 13'(n_kills);
    assign pontos_sat = (soma > 13'(PONTOS_MAX)) ? 10'(PONTOS_MAX) : soma[9:0];

`ifdef CONTROLE_INVULNERAVEL_EN
    logic [25:0] inv_cnt, inv_cnt_n;
    assign hit_ok = hit && (inv_cnt == '0);
`else
    assign hit_ok = hit;
`endif

    always_comb begin
        est_n       = est;
        vidas_n     = vidas;
        pontos_n    = pontos;
        vitoria_n   = vitoria;
        reiniciar_n = 1'b0;
`ifdef CONTROLE_INVULNERAVEL_EN
        inv_cnt_n   = inv_cnt;
`endif
        case (est)
            INICIO: begin
`ifdef CONTROLE_INVULNERAVEL_EN
                inv_cnt_n = '0;
`endif
                if (ev_start) begin
                    est_n       = JOGANDO;
                    reiniciar_n = 1'b1;
                    vidas_n     = 2'(VIDAS_INI);
                    pontos_n    = '0;
                    vitoria_n   = 1'b0;
                end
            end
            JOGANDO: begin
                pontos_n = pontos_sat;
`ifdef CONTROLE_INVULNERAVEL_EN
                if (inv_cnt != '0)
                    inv_cnt_n = inv_cnt - 26'd1;
`endif
                // Defeat is checked first so it wins over a same-cycle victory.
                if (hit_ok) begin
`ifdef CONTROLE_INVULNERAVEL_EN
                    inv_cnt_n = 26'(INV_CICLOS);
`endif
                    if (vidas > 2'd1) begin
                        vidas_n = vidas - 2'd1;
                    end else begin
                        vidas_n   = 2'd0;
                        est_n     = FIM;
                        vitoria_n = 1'b0;
                    end
                end else if (inimigo_vivo_array == '0 && !reiniciarJogo) begin
                    est_n     = FIM;
                    vitoria_n = 1'b1;
                end
                if (ev_pausa && est_n == JOGANDO)
                    est_n = PAUSADO;
            end
            PAUSADO: begin
                if (ev_pausa)
                    est_n = JOGANDO;
            end
            FIM: begin
                if (ev_start)
                    est_n = INICIO;
            end
            default: est_n = INICIO;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            est           <= INICIO;
            vidas         <= 2'(VIDAS_INI);
            pontos        <= '0;
            vitoria       <= 1'b0;
            reiniciarJogo <= 1'b0;
            key_q         <= '0;
            key_prev      <= '0;
            sobre_q       <= 1'b0;
            sobre_prev    <= 1'b0;
            prev_vivo     <= '0;
`ifdef CONTROLE_INVULNERAVEL_EN
            inv_cnt       <= '0;
`endif
        end else begin
            est           <= est_n;
            vidas         <= vidas_n;
            pontos        <= pontos_n;
            vitoria       <= vitoria_n;
            reiniciarJogo <= reiniciar_n;
            key_q         <= keysout[1:0];
            key_prev      <= key_q;
            sobre_q       <= sobrepoe;
            sobre_prev    <= sobre_q;
            prev_vivo     <= inimigo_vivo_array;
`ifdef CONTROLE_INVULNERAVEL_EN
            inv_cnt       <= inv_cnt_n;
`endif
        end
    end

    assign estado = est;
    assign pausa  = (est != JOGANDO);

endmodule

// File: tb/tb_controle_jogo.sv
// Scoreboard bench for controle_jogo: expected output snapshots are queued with the stimulus and
// compared when the DUT has had time to respond.
module tb_controle_jogo;

    localparam int PMAX = 55;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] keysout;
    logic [9:0] x_nave, y_nave, x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic [0:4] inimigo_vivo_array;
    logic       pausa, reiniciarJogo, vitoria;
    logic [1:0] estado, vidas;
    logic [9:0] pontos;

    always #5 CLOCK_50 = ~CLOCK_50;

    controle_jogo #(
        .PONTOS_MAX(PMAX)
`ifdef CONTROLE_INVULNERAVEL_EN
        , .INV_CICLOS(20)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .keysout(keysout),
        .x_nave(x_nave), .y_nave(y_nave),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
        .raio_bola_inimiga(raio_bola_inimiga), .inimigo_vivo_array(inimigo_vivo_array),
        .pausa(pausa), .reiniciarJogo(reiniciarJogo), .estado(estado),
        .vidas(vidas), .pontos(pontos), .vitoria(vitoria)
    );

    typedef struct {
        string tag;
        int    est;
        int    vid;
        int    pts;
        int    vit;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_pts;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic push_exp(input string tag, input int e, input int v, input int p, input int vit);
        exp_t x;
        x.tag = tag; x.est = e; x.vid = v; x.pts = p; x.vit = vit;
        sb.push_back(x);
    endtask

    task automatic pop_cmp();
        exp_t x;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk({x.tag, ".estado"},  int'(estado),  x.est);
            chk({x.tag, ".vidas"},   int'(vidas),   x.vid);
            chk({x.tag, ".pontos"},  int'(pontos),  x.pts);
            chk({x.tag, ".vitoria"}, int'(vitoria), x.vit);
            chk({x.tag, ".pausa"},   int'(pausa),   (x.est != 1) ? 1 : 0);
        end
    endtask

    function automatic int add_pts(input int p, input int kills);
        int s;
        s = p + 10 * kills;
        return (s > PMAX) ? PMAX : s;
    endfunction

    task automatic ball_on();
        x_bola_inimiga = 10'd120; y_bola_inimiga = 10'd300;
    endtask

    task automatic ball_off();
        x_bola_inimiga = 10'd200; y_bola_inimiga = 10'd300;
    endtask

    // Hold a key until the FSM reaches the target state (bounded), then release it.
    task automatic key_to(input int idx, input int target, input string tag);
        keysout[idx] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (int'(estado) == target) break;
        end
        keysout[idx] = 1'b0;
        chk(tag, int'(estado), target);
        cyc(3);
    endtask

    task automatic start_game(input string tag);
        keysout[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (estado == 2'd1) break;
        end
        chk({tag, ".estado"}, int'(estado), 1);
        chk({tag, ".rein_first"}, int'(reiniciarJogo), 1);
        cyc(1);
        chk({tag, ".rein_second"}, int'(reiniciarJogo), 0);
        keysout[0] = 1'b0;
        cyc(3);
    endtask

    task automatic set_vivo(input logic [0:4] v, input int kills, input string tag, input int v_exp);
        inimigo_vivo_array = v;
        m_pts = add_pts(m_pts, kills);
        push_exp(tag, 1, v_exp, m_pts, 0);
        cyc(2);
        pop_cmp();
    endtask

    initial begin
        reset = 1'b1;
        keysout = '0;
        x_nave = 10'd100; y_nave = 10'd295; raio_bola_inimiga = 10'd5;
        ball_off();
        inimigo_vivo_array = 5'b11111;
        m_pts = 0;
        cyc(3);
        push_exp("reset", 0, 3, 0, 0);
        pop_cmp();
        chk("reset.rein", int'(reiniciarJogo), 0);
        reset = 1'b0;
        cyc(2);
        key_to(1, 0, "inicio_pause_ignored");

        // Game 1: scoring, respawn, hit latency, pause, then defeat on last enemy
        start_game("g1");
        push_exp("g1_start", 1, 3, 0, 0); pop_cmp();
        set_vivo(5'b01111, 1, "kill1", 3);
        set_vivo(5'b00110, 2, "kill2", 3);
        set_vivo(5'b00111, 0, "respawn", 3);

        cyc(5);
        push_exp("miss", 1, 3, m_pts, 0); pop_cmp();
        ball_on();
        cyc(1);
        push_exp("hit_lat1", 1, 3, m_pts, 0); pop_cmp();
        cyc(1);
        push_exp("hit_lat2", 1, 2, m_pts, 0); pop_cmp();
        cyc(100);
        push_exp("hit_held", 1, 2, m_pts, 0); pop_cmp();
        ball_off();
        cyc(5);

        key_to(1, 2, "pause");
        inimigo_vivo_array = 5'b00101;
        ball_on();
        cyc(5);
        keysout[0] = 1'b1; cyc(3); keysout[0] = 1'b0; cyc(3);
        push_exp("paused", 2, 2, m_pts, 0); pop_cmp();
        key_to(1, 1, "resume");
        cyc(3);
        push_exp("resumed", 1, 2, m_pts, 0); pop_cmp();
        ball_off();
        cyc(5);

        set_vivo(5'b00100, 1, "kill3", 2);
        ball_on(); cyc(3);
        push_exp("hit2", 1, 1, m_pts, 0); pop_cmp();
        ball_off(); cyc(5);

        ball_on(); cyc(1);
        inimigo_vivo_array = 5'b00000;
        m_pts = add_pts(m_pts, 1);
        cyc(2);
        push_exp("defeat", 3, 0, m_pts, 0); pop_cmp();
        ball_off();
        cyc(3);

        // Game 2: restart holds results in INICIO, then saturating score and victory
        inimigo_vivo_array = 5'b11111;
        cyc(2);
        key_to(0, 0, "fim_to_inicio");
        push_exp("inicio_hold", 0, 0, m_pts, 0); pop_cmp();
        start_game("g2");
        m_pts = 0;
        push_exp("g2_start", 1, 3, 0, 0); pop_cmp();
        set_vivo(5'b00001, 4, "g2_kill4", 3);
        set_vivo(5'b11111, 0, "g2_respawn", 3);
        set_vivo(5'b10000, 4, "g2_saturate", 3);
        inimigo_vivo_array = 5'b00000;
        cyc(2);
        push_exp("victory", 3, 3, PMAX, 1); pop_cmp();

        // Game 3: hits at t, t+10, t+30
        inimigo_vivo_array = 5'b11111;
        cyc(2);
        key_to(0, 0, "fim_to_inicio2");
        start_game("g3");
        m_pts = 0;
        ball_on(); cyc(3); ball_off(); cyc(2);
        push_exp("inv_t", 1, 2, 0, 0); pop_cmp();
        cyc(5);
        ball_on(); cyc(3); ball_off(); cyc(2);
`ifdef CONTROLE_INVULNERAVEL_EN
        push_exp("inv_t10", 1, 2, 0, 0); pop_cmp();
`else
        push_exp("inv_t10", 1, 1, 0, 0); pop_cmp();
`endif
        cyc(15);
        ball_on(); cyc(3); ball_off(); cyc(2);
`ifdef CONTROLE_INVULNERAVEL_EN
        push_exp("inv_t30", 1, 1, 0, 0); pop_cmp();
`else
        push_exp("inv_t30", 3, 0, 0, 0); pop_cmp();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
